// File: rtl/result_serializer.sv
// Captures a WIDTH-bit compressor result and streams it out LSB first
// over a valid/ready serial port, counting completed frames.
module result_serializer #(
  parameter int WIDTH = 51,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dst_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             parity
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(WIDTH - 2);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [IDX_W-1:0] idx;

  assign ser_out = sreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      idx        <= '0;
      frame_cnt  <= '0;
      parity     <= 1'b0;
      load_ready <= 1'b1;
      ser_valid  <= 1'b0;
      ser_last   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            state      <= SHIFT;
            sreg       <= dst_in;
            idx        <= '0;
            parity     <= ^dst_in;
            load_ready <= 1'b0;
            ser_valid  <= 1'b1;
            ser_last   <= 1'b0;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
            if (idx == LAST) begin
              state      <= IDLE;
              idx        <= '0;
              frame_cnt  <= frame_cnt + CNT_W'(1);
              load_ready <= 1'b1;
              ser_valid  <= 1'b0;
              ser_last   <= 1'b0;
            end else begin
              idx      <= idx + IDX_W'(1);
              // flag the final column one transfer ahead
              ser_last <= (idx == PRE_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 51, number of compressor result columns (dst0..dst(WIDTH-1)) captured per frame; legal range 2..255.
REQ-002 SHALL provide parameter CNT_W, default 8, width of the completed-frame counter.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port dst_in, input, WIDTH, parallel compressor result; bit i = column dst(i).
REQ-006 SHALL provide port load_valid, input, 1, upstream asserts when dst_in holds a result to capture.
REQ-007 SHALL provide port load_ready, output, 1, block can accept a capture.
REQ-008 SHALL provide port ser_out, output, 1, current serial result bit.
REQ-009 SHALL provide port ser_valid, output, 1, ser_out carries a valid bit.
REQ-010 SHALL provide port ser_ready, input, 1, downstream accepts the bit when high with ser_valid.
REQ-011 SHALL provide port ser_last, output, 1, marks the final bit (column WIDTH-1) of a frame.
REQ-012 SHALL provide port frame_cnt, output, CNT_W, count of fully transmitted frames.
REQ-013 SHALL provide port parity, output, 1, XOR of all WIDTH bits of the most recently captured frame.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-015 In IDLE, load_ready SHALL be 1, ser_valid 0, ser_last 0.
REQ-016 In IDLE, load_valid=1 at a clock edge SHALL capture dst_in into an internal WIDTH-bit shift register, clear the bit index to 0, update parity, and enter SHIFT.
REQ-017 In SHIFT, load_ready SHALL be 0, ser_valid 1, ser_out = shift register bit 0; load_valid SHALL be ignored.
REQ-018 Bits SHALL be sent LSB first: column 0 first, column WIDTH-1 last.
REQ-019 A bit transfer SHALL occur on an edge where ser_valid=1 and ser_ready=1; the register then shifts right one place (0 in at MSB) and the index increments.
REQ-020 With ser_ready=0, ser_out, ser_last and the index SHALL hold unchanged.
REQ-021 ser_last SHALL be 1 exactly while in SHIFT with index = WIDTH-1.
REQ-022 Transfer of the last bit SHALL return the FSM to IDLE and increment frame_cnt by 1, wrapping modulo 2^CNT_W.
REQ-023 Latency: first bit valid the cycle after capture; with ser_ready held 1 a frame occupies exactly WIDTH cycles in SHIFT; next capture possible one cycle later (frame period WIDTH+1).
REQ-024 All outputs SHALL be registered or decoded solely from registered state; no combinational path from ser_ready or load_valid to any output.
REQ-025 parity SHALL hold its value until the next capture.

Reset
REQ-026 rst_n=0 SHALL immediately, regardless of clock: FSM to IDLE, shift register, index, frame_cnt, parity to 0; hence load_ready=1, ser_valid=0, ser_out=0, ser_last=0.
REQ-027 Reset asserted mid-frame SHALL abort it; the partial frame SHALL NOT increment frame_cnt.
REQ-028 After rst_n deasserts, the first capture SHALL be accepted no earlier than the first rising edge with rst_n=1.

Verification
REQ-029 Reset then WIDTH=51, dst_in=51'h5_5555_5555_5555, load_valid one cycle, ser_ready=1 -> 51 bits 1,0,1,0,...,1; ser_last only on 51st; frame_cnt=1; parity=0 (26 ones).
REQ-030 WIDTH=4, dst_in=4'b1011, ser_ready toggling 1,0,1,0 -> ser_out sequence 1,1,0,1, each held through stall cycles; ser_last with the 4th bit only.
REQ-031 load_valid held high during SHIFT with changing dst_in -> no recapture; transmitted frame equals the value present at capture edge; next capture taken one cycle after last bit.
REQ-032 rst_n pulsed low after 10 of 51 bits -> outputs at reset values asynchronously; frame_cnt stays at previous value (0 after reset); fresh capture afterwards transmits correctly.
REQ-033 CNT_W=8, 256 back-to-back frames with ser_ready=1 -> frame_cnt wraps 255->0; load_ready high exactly one cycle between frames.
REQ-034 Random dst_in and random ser_ready over 1000 frames -> scoreboard reassembles each frame bit-exact and parity matches XOR of captured value.
